// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and field positions for decode_stage_p
package decode_pkg;

    localparam int OPW      = 4;
    localparam int IR_W     = 16;
    localparam int OP_LSB   = 0;
    localparam int RD_LSB   = 4;
    localparam int RS1_LSB  = 8;
    localparam int RS2_LSB  = 12;
    localparam int XLEN_MAX = 64;
    localparam int RAW_MAX  = 4;

    typedef enum logic [1:0] {
        IMM_S4  = 2'd0,
        IMM_S8  = 2'd1,
        IMM_U8  = 2'd2,
        IMM_S12 = 2'd3
    } imm_op_e;

    // Fields sized for the widest build; narrower builds use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] a;
        logic [XLEN_MAX-1:0] b;
        logic [XLEN_MAX-1:0] imm;
        logic [RAW_MAX-1:0]  rd;
        logic [OPW-1:0]      op;
    } decode_bundle_t;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - NREG x XLEN register file, two read ports, one write port, r0 reads zero
module regfile_2r1w #(
    parameter int XLEN = 16,
    parameter int NREG = 16,
    parameter int RAW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RAW-1:0]  raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [RAW-1:0]  raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - handshaked decode stage with register file read; DECODE_BYPASS_EN enables writeback-to-decode bypass
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int NREG = 16,
    parameter int RAW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    input  logic [1:0]      in_immop,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_imm,
    output logic [RAW-1:0]  out_rd,
    output logic [OPW-1:0]  out_op
);

    if (RAW != $clog2(NREG)) begin : g_raw_chk
        $error("decode_stage_p: RAW must equal clog2(NREG)");
    end
    if (NREG < 2 || NREG > 16 || (NREG & (NREG - 1)) != 0) begin : g_nreg_chk
        $error("decode_stage_p: NREG must be a power of two in 2..16");
    end
    if (XLEN < 16 || XLEN > XLEN_MAX) begin : g_xlen_chk
        $error("decode_stage_p: XLEN out of range");
    end

    logic [RAW-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0] rf_a, rf_b, opnd_a, opnd_b, imm;
    logic            accept;
    decode_bundle_t  bundle_d, bundle_q;
    logic            valid_q;

    assign rd  = in_ir[RD_LSB  +: RAW];
    assign rs1 = in_ir[RS1_LSB +: RAW];
    assign rs2 = in_ir[RS2_LSB +: RAW];

    regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs1),
        .rdata_a (rf_a),
        .raddr_b (rs2),
        .rdata_b (rf_b)
    );

`ifdef DECODE_BYPASS_EN
    assign opnd_a = (wb_en && wb_rd == rs1 && rs1 != '0) ? wb_data : rf_a;
    assign opnd_b = (wb_en && wb_rd == rs2 && rs2 != '0) ? wb_data : rf_b;
`else
    // Same-cycle writeback is not visible here; upstream must insert a bubble.
    assign opnd_a = rf_a;
    assign opnd_b = rf_b;
`endif

    always_comb begin
        imm = '0;
        case (imm_op_e'(in_immop))
            IMM_S4:  imm = XLEN'($signed(in_ir[15:12]));
            IMM_S8:  imm = XLEN'($signed(in_ir[15:8]));
            IMM_U8:  imm = XLEN'({in_ir[15:8], 8'h00});
            IMM_S12: imm = XLEN'($signed(in_ir[15:4]));
            default: imm = '0;
        endcase
    end

    always_comb begin
        bundle_d     = '0;
        bundle_d.pc  = XLEN_MAX'(in_pc);
        bundle_d.a   = XLEN_MAX'(opnd_a);
        bundle_d.b   = XLEN_MAX'(opnd_b);
        bundle_d.imm = XLEN_MAX'(imm);
        bundle_d.rd  = RAW_MAX'(rd);
        bundle_d.op  = in_ir[OP_LSB +: OPW];
    end

    assign in_ready = !rst && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (out_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = bundle_q.pc[XLEN-1:0];
    assign out_a     = bundle_q.a[XLEN-1:0];
    assign out_b     = bundle_q.b[XLEN-1:0];
    assign out_imm   = bundle_q.imm[XLEN-1:0];
    assign out_rd    = bundle_q.rd[RAW-1:0];
    assign out_op    = bundle_q.op;

    logic unused_bundle_bits;
    assign unused_bundle_bits = ^bundle_q;

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised decode pipeline stage. Splits a fetched instruction into register fields and reads two operands from an internal register file. Generates the immediate and registers everything into a single decode/execute pipeline register.
- Adds three things the fixed 16-bit decode cycle lacks: valid/ready handshakes on both sides, a flush, and configurable width and register count. Writeback-to-decode bypass is optional.
- Sits between the fetch stage and the execute stage. Writeback from the last stage re-enters through the wb_* port.

Parameters:
- XLEN, 16, datapath and PC width in bits (≥16).
- NREG, 16, register count (power of two, 2..16); register 0 is hardwired to zero.
- RAW, 4, register address width; must equal clog2(NREG), checked by an elaboration assertion.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_ir  in  16  instruction; fields are opcode=ir[3:0], rd=ir[7:4], rs1=ir[11:8], rs2=ir[15:12].
- in_pc  in  XLEN  PC of in_ir.
- in_immop  in  2  immediate format select.
- flush  in  1  kill the held and incoming instruction.
- wb_en  in  1  register write enable.
- wb_rd  in  RAW  write address.
- wb_data  in  XLEN  write data.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  registered PC.
- out_a  out  XLEN  rs1 operand.
- out_b  out  XLEN  rs2 operand.
- out_imm  out  XLEN  immediate.
- out_rd  out  RAW  destination.
- out_op  out  4  opcode.

Behaviour:
- Reset: all out_* = 0, out_valid = 0, and every register-file entry = 0, asynchronously. in_ready is 0 while rst is high and 1 on the first cycle after release.
- in_ready = !out_valid || out_ready (one-entry pipeline register, no skid).
- Accept = in_valid && in_ready && !flush. On accept, the pipeline register loads the full bundle; latency is 1 cycle, in to out.
- Pipeline register update:
  - out_ready && out_valid && !accept → out_valid ← 0.
  - !out_ready && out_valid → all outputs hold stable; operands are NOT re-read while held.
- flush: next cycle out_valid = 0, and the input is not accepted that cycle. flush has priority over accept and hold.
- Field truncation: register fields use the low RAW bits when NREG < 16.
- Register file:
  - NREG×XLEN; write on the clock edge when wb_en && wb_rd != 0.
  - Writes to r0 are ignored; reads of r0 return 0.
- Immediate generation (all results XLEN wide):
  - immop 0 = sign-extend ir[15:12].
  - immop 1 = sign-extend ir[15:8].
  - immop 2 = zero-extend ir[15:8] shifted left 8.
  - immop 3 = sign-extend ir[15:4].
- Simultaneous write and read of the same register: see the optional feature.
- The writeback port is independent of the handshake: writes occur even when in_valid = 0 or the stage is stalled or flushed.
- Reset mid-operation discards the held bundle; no partial register-file write completes.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: when accepting with wb_en && wb_rd == rs && rs != 0, the operand captured is wb_data (write-through read).
- Undefined: the operand captured is the pre-write register contents. Software or hazard logic upstream must insert a bubble.

Decomposition:
- Shared package decode_pkg:
  - immop encodings IMM_S4, IMM_S8, IMM_U8, IMM_S12.
  - Instruction field bit positions.
  - Opcode width constant.
  - Bundle typedef decode_bundle_t (pc, a, b, imm, rd, op).
- Sub-module regfile_2r1w (async-reset, r0-zero, 2 read / 1 write). The immediate mux stays inline.

Test Plan:
- Reset then read: assert rst mid-stream with out_valid = 1. Required: out_valid = 0 immediately; after release, decode ir=0x2105 (rd=0, rs1=1, rs2=2) → out_a = 0, out_b = 0.
- Writeback then decode:
  - wb r3 = 0x1234.
  - Next cycle, accept ir=0x4330, immop=1. Required: out_a = 0x1234, out_rd = 3, out_imm = 0x0043.
- Same-cycle write and read of r5 (old value 0x0011, wb_data 0x00AA):
  - With DECODE_BYPASS_EN: out_a = 0x00AA.
  - Without it: out_a = 0x0011.
- Backpressure: hold out_ready = 0 for 3 cycles while in_valid = 1. Required: in_ready = 0, outputs stable, including across a wb write to the same source register. Release → the next bundle appears 1 cycle later.
- Flush: flush with out_valid = 1 and in_valid = 1. Required: out_valid = 0 next cycle, and the input instruction never appears.
- Immediates:
  - ir=0xF000, immop 0 → 0xFFFF; immop 2 → 0xF000; immop 3 → 0xFF00.
  - With XLEN = 32, immop 0 → 0xFFFFFFFF.
  - Write to r0 then read r0 → 0.
